// File: rtl/scan_sched.sv
// scan_sched: shares one prescaled tick between the display refresh and keypad scan.
//   clk, clr (sync active-low) ; en scan enable ; row_ack decoder took the row sample
//   an/col active-low one-hot digit anodes and keypad columns ; dig_sel slot index
//   row_stb rows valid for column dig_sel until acked ; frame_stb pulse on index wrap 3->0
module scan_sched #(
  parameter int PRESCALE = 25000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       row_ack,
  output logic [3:0] an,
  output logic [3:0] col,
  output logic [1:0] dig_sel,
  output logic       row_stb,
  output logic       frame_stb
);
  localparam int CW = $clog2(PRESCALE);
  typedef enum logic [1:0] {IDLE, DISP, KDRV, KSMP} state_t;
  state_t state;
  logic [1:0] idx;
  logic [CW-1:0] count;
  logic tick;
  assign tick = count == CW'(PRESCALE - 1);
  assign dig_sel = idx;
  function automatic logic [3:0] sel(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction
  // Outputs are loaded together with the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (!clr || !en) begin
      state <= IDLE;
      idx <= 2'd0;
      count <= '0;
      an <= 4'hF;
      col <= 4'hF;
      row_stb <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      count <= count + CW'(1);
      case (state)
        IDLE: begin
          state <= DISP;
          idx <= 2'd0;
          count <= '0;
          an <= sel(2'd0);
        end
        DISP: if (tick) begin
          state <= KDRV;
          count <= '0;
          an <= 4'hF;
          col <= sel(idx);
        end
        KDRV: if (tick) begin
          state <= KSMP;
          count <= '0;
          row_stb <= 1'b1;
        end
        default: if (row_ack) begin
          state <= DISP;
          count <= '0;
          idx <= idx + 2'd1;
          an <= sel(idx + 2'd1);
          col <= 4'hF;
          row_stb <= 1'b0;
          frame_stb <= idx == 2'd3;
        end
      endcase
    end
  end
endmodule
